// File: rtl/instr_dispatch_fsm.sv
// instr_dispatch_fsm: fetch/decode/issue controller driving ALU, MOV and LOAD sequencers.
// Define DISPATCH_TIMEOUT_EN to add a WAIT watchdog that faults and halts after TIMEOUT cycles.
module instr_dispatch_fsm #(
  parameter int PC_W        = 6,
  parameter int REG_FIELD_W = 6,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  output logic [PC_W-1:0]        imem_addr,
  output logic                   imem_rd,
  input  logic [7:0]             instr,
  output logic                   alu_start,
  output logic [2:0]             alu_op,
  input  logic                   alu_done,
  output logic                   mov_start,
  input  logic                   mov_done,
  output logic                   load_start,
  input  logic                   load_done,
  output logic [REG_FIELD_W-1:0] Ri,
  output logic [REG_FIELD_W-1:0] Rj,
  output logic                   busy,
  output logic                   halted,
  output logic                   fault,
  output logic [15:0]            retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT, NEXT, HALTED} state_t;
  state_t state, nxt;
  logic [PC_W-1:0] pc;
  logic [3:0] ir, op;
  logic op_unit, done_hit, timed_out;
  assign imem_addr = pc;
  assign op = instr[7:4];
  assign op_unit = op[3] | (op == 4'd1) | (op == 4'd2);
  // only the done pulse of the unit that was started may end WAIT
  assign done_hit = (ir[3] & alu_done) | ((ir == 4'd1) & mov_done) | ((ir == 4'd2) & load_done);
`ifdef DISPATCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign timed_out = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      fault <= 1'b0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (state == WAIT && nxt == HALTED) fault <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign fault = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = run ? FETCH : IDLE;
      FETCH:   nxt = DECODE;
      DECODE:  nxt = (op == 4'd3) ? HALTED : op_unit ? ISSUE : NEXT;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = done_hit ? NEXT : timed_out ? HALTED : WAIT;
      NEXT:    nxt = run ? FETCH : IDLE;
      default: nxt = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      imem_rd <= 1'b0;
      alu_start <= 1'b0;
      mov_start <= 1'b0;
      load_start <= 1'b0;
      alu_op <= '0;
      Ri <= '0;
      Rj <= '0;
      busy <= 1'b0;
      halted <= 1'b0;
      retired <= '0;
    end else begin
      state <= nxt;
      imem_rd <= nxt == FETCH;
      busy <= nxt != IDLE && nxt != HALTED;
      halted <= nxt == HALTED;
      alu_start <= state == DECODE && op[3];
      mov_start <= state == DECODE && op == 4'd1;
      load_start <= state == DECODE && op == 4'd2;
      if (state == DECODE) begin
        ir <= op;
        alu_op <= op[2:0];
        Ri <= REG_FIELD_W'(instr[3:2]);
        Rj <= REG_FIELD_W'(instr[1:0]);
      end
      if (state == NEXT) begin
        pc <= pc + 1'b1;
        retired <= retired + {15'd0, retired != 16'hFFFF};
      end
    end
  end
endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// tb_instr_dispatch_fsm: randomized and directed checks of instr_dispatch_fsm against an instruction-level model.
module tb_instr_dispatch_fsm;
  typedef struct packed {logic [1:0] u; logic [2:0] op; logic [5:0] ri; logic [5:0] rj;} ev_t;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0;
  logic [5:0] imem_addr, Ri, Rj;
  logic imem_rd, alu_start, mov_start, load_start, busy, halted, fault;
  logic alu_done = 1'b0, mov_done = 1'b0, load_done = 1'b0;
  logic [7:0] instr;
  logic [2:0] alu_op;
  logic [15:0] retired;
  logic [7:0] mem [64];
  ev_t starts[$];
  ev_t hold;
  int n_chk = 0, n_fail = 0, n_multi = 0, stab_err = 0;
  int pend = 0, pend_u = 0, lat_lo = 5, lat_hi = 5;
  bit auto_done = 0, spur = 0, watching = 0, prev_rd = 0;

  instr_dispatch_fsm dut (
    .clk(clk), .reset(reset), .run(run), .imem_addr(imem_addr), .imem_rd(imem_rd), .instr(instr),
    .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done),
    .mov_start(mov_start), .mov_done(mov_done), .load_start(load_start), .load_done(load_done),
    .Ri(Ri), .Rj(Rj), .busy(busy), .halted(halted), .fault(fault), .retired(retired)
  );

  initial forever #5 clk = ~clk;

  // instruction memory: word appears after the fetch strobe, garbage otherwise
  initial begin
    instr = 8'h00;
    forever begin
      @(negedge clk);
      if (imem_rd) instr = mem[imem_addr];
      else if (!prev_rd) instr = 8'($urandom);
      prev_rd = imem_rd;
    end
  end

  // execution units: done after a random latency, plus stray dones from idle units
  initial forever begin
    @(negedge clk);
    if (auto_done) begin
      alu_done = 0; mov_done = 0; load_done = 0;
      if (reset) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          alu_done = pend_u == 1; mov_done = pend_u == 2; load_done = pend_u == 3;
        end else if (spur && $urandom_range(3) == 0) begin
          int su;
          su = $urandom_range(1, 3);
          if (su != pend_u) begin
            alu_done = su == 1; mov_done = su == 2; load_done = su == 3;
          end
        end
      end else if (alu_start | mov_start | load_start) begin
        pend_u = alu_start ? 1 : mov_start ? 2 : 3;
        pend = $urandom_range(lat_lo, lat_hi);
      end
    end
  end

  // start-pulse recorder and operand stability watcher
  initial forever begin
    @(negedge clk);
    if (reset) watching = 0;
    else if (alu_start | mov_start | load_start) begin
      if ($countones({alu_start, mov_start, load_start}) > 1) n_multi++;
      hold.u = alu_start ? 2'd1 : mov_start ? 2'd2 : 2'd3;
      hold.op = alu_op; hold.ri = Ri; hold.rj = Rj;
      starts.push_back(hold);
      watching = 1;
    end else if (watching) begin
      if (imem_rd || !busy) watching = 0;
      else if ({alu_op, Ri, Rj} !== {hold.op, hold.ri, hold.rj}) stab_err++;
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    reset = 1; run = 0; auto_done = 0; spur = 0; pend = 0;
    alu_done = 0; mov_done = 0; load_done = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    starts.delete();
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  task automatic wait_halt(input int bound);
    for (int i = 0; i < bound && !halted; i++) @(negedge clk);
    n_chk++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_timeout: halted=%0b want 1", halted); end
  endtask

  task automatic test_reset();
    reset_dut();
    repeat (3) @(negedge clk);
    n_chk++; if (imem_addr !== 6'd0) begin n_fail++; $display("FAIL rst_pc: got %0d want 0", imem_addr); end
    n_chk++; if ({imem_rd, alu_start, mov_start, load_start} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 0000", {imem_rd, alu_start, mov_start, load_start}); end
    n_chk++; if ({alu_op, Ri, Rj} !== 15'd0) begin n_fail++; $display("FAIL rst_fields: got %h want 0", {alu_op, Ri, Rj}); end
    n_chk++; if ({busy, halted, fault} !== 3'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {busy, halted, fault}); end
    n_chk++; if (retired !== 16'd0) begin n_fail++; $display("FAIL rst_retired: got %0d want 0", retired); end
  endtask

  task automatic test_program();
    reset_dut();
    fill_mem(8'h00);
    mem[0] = 8'h81; mem[1] = 8'h16; mem[2] = 8'h30;
    lat_lo = 5; lat_hi = 5; auto_done = 1; run = 1;
    wait_halt(200);
    n_chk++; if (starts.size() != 2) begin n_fail++; $display("FAIL prog_nstarts: got %0d want 2", starts.size()); end
    else begin
      n_chk++; if (starts[0] !== ev_t'{2'd1, 3'd0, 6'd0, 6'd1}) begin n_fail++; $display("FAIL prog_alu: got %h want %h", starts[0], ev_t'{2'd1, 3'd0, 6'd0, 6'd1}); end
      n_chk++; if ({starts[1].u, starts[1].ri, starts[1].rj} !== {2'd2, 6'd1, 6'd2}) begin n_fail++; $display("FAIL prog_mov: got %h want u2 ri1 rj2", starts[1]); end
    end
    n_chk++; if (imem_addr !== 6'd2) begin n_fail++; $display("FAIL prog_pc: got %0d want 2", imem_addr); end
    n_chk++; if (retired !== 16'd2) begin n_fail++; $display("FAIL prog_retired: got %0d want 2", retired); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prog_busy: got %b want 0", busy); end
  endtask

  task automatic test_nop();
    int n;
    reset_dut();
    fill_mem(8'h30);
    mem[0] = 8'h00;
    run = 1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n = i;
      if (retired == 16'd1) break;
    end
    // one cycle to leave IDLE, then FETCH, DECODE, NEXT
    n_chk++; if (n != 4) begin n_fail++; $display("FAIL nop_latency: got %0d want 4", n); end
    wait_halt(20);
    n_chk++; if (imem_addr !== 6'd1) begin n_fail++; $display("FAIL nop_pc: got %0d want 1", imem_addr); end
    n_chk++; if (retired !== 16'd1) begin n_fail++; $display("FAIL nop_retired: got %0d want 1", retired); end
    n_chk++; if (starts.size() != 0) begin n_fail++; $display("FAIL nop_starts: got %0d want 0", starts.size()); end
  endtask

  task automatic test_ignore_other_done();
    logic [2:0] op;
    logic [1:0] ri, rj;
    bit found;
    reset_dut();
    fill_mem(8'h30);
    op = 3'($urandom); ri = 2'($urandom); rj = 2'($urandom);
    mem[0] = {1'b1, op, ri, rj};
    run = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); found = alu_start; end
    n_chk++; if (!found) begin n_fail++; $display("FAIL ign_start: got 0 want alu_start"); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      load_done = k == 1;
      mov_done = k == 3;
    end
    @(negedge clk);
    load_done = 0; mov_done = 0;
    n_chk++; if ({busy, retired} !== {1'b1, 16'd0}) begin n_fail++; $display("FAIL ign_stray: busy=%b retired=%0d want busy=1 retired=0", busy, retired); end
    n_chk++; if ({alu_op, Ri, Rj} !== {op, 4'd0, ri, 4'd0, rj}) begin n_fail++; $display("FAIL ign_fields: got %h want %h", {alu_op, Ri, Rj}, {op, 4'd0, ri, 4'd0, rj}); end
    alu_done = 1;
    @(negedge clk);
    alu_done = 0;
    @(negedge clk);
    n_chk++; if (retired !== 16'd1) begin n_fail++; $display("FAIL ign_retire: got %0d want 1", retired); end
    wait_halt(20);
    n_chk++; if (stab_err != 0) begin n_fail++; $display("FAIL ign_stable: got %0d changes want 0", stab_err); end
  endtask

  task automatic test_run_drop();
    bit found;
    reset_dut();
    fill_mem(8'h30);
    mem[0] = 8'h1B;
    lat_lo = 8; lat_hi = 8; auto_done = 1; run = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); found = mov_start; end
    @(negedge clk);
    run = 0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_chk++; if ({busy, halted} !== 2'b00) begin n_fail++; $display("FAIL drop_idle: busy=%b halted=%b want 0 0", busy, halted); end
    n_chk++; if ({imem_addr, retired} !== {6'd1, 16'd1}) begin n_fail++; $display("FAIL drop_pc: pc=%0d retired=%0d want 1 1", imem_addr, retired); end
    run = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin @(negedge clk); found = imem_rd; end
    n_chk++; if ({found, imem_addr} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL drop_resume: fetch=%b addr=%0d want 1 1", found, imem_addr); end
    wait_halt(20);
    n_chk++; if (starts.size() != 1) begin n_fail++; $display("FAIL drop_starts: got %0d want 1", starts.size()); end
  endtask

  task automatic test_wrap();
    reset_dut();
    fill_mem(8'h00);
    run = 1;
    for (int i = 0; i < 400 && imem_addr != 6'd63; i++) @(negedge clk);
    n_chk++; if ({imem_addr, retired} !== {6'd63, 16'd63}) begin n_fail++; $display("FAIL wrap_63: pc=%0d retired=%0d want 63 63", imem_addr, retired); end
    for (int i = 0; i < 10 && retired != 16'd64; i++) @(negedge clk);
    n_chk++; if ({imem_addr, retired} !== {6'd0, 16'd64}) begin n_fail++; $display("FAIL wrap_0: pc=%0d retired=%0d want 0 64", imem_addr, retired); end
    run = 0;
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    reset_dut();
    fill_mem(8'h30);
    mem[0] = 8'h00; mem[1] = 8'h9E;
    run = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); found = alu_start; end
    repeat (3) @(negedge clk);
    n_chk++; if ({found, busy, imem_addr, Ri} !== {2'b11, 6'd1, 6'd3}) begin n_fail++; $display("FAIL rmw_pre: start=%b busy=%b pc=%0d Ri=%0d want 1 1 1 3", found, busy, imem_addr, Ri); end
    reset = 1; run = 0;
    @(negedge clk);
    n_chk++; if ({imem_addr, imem_rd, alu_start, mov_start, load_start} !== 10'd0) begin n_fail++; $display("FAIL rmw_ctl: got %h want 0", {imem_addr, imem_rd, alu_start, mov_start, load_start}); end
    n_chk++; if ({alu_op, Ri, Rj, busy, halted, fault, retired} !== 34'd0) begin n_fail++; $display("FAIL rmw_out: got %h want 0", {alu_op, Ri, Rj, busy, halted, fault, retired}); end
    reset = 0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int len;
      ev_t exp_q[$];
      ev_t e;
      logic [7:0] b;
      reset_dut();
      len = $urandom_range(5, 40);
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < len; i++) begin
        do b = 8'($urandom); while (b[7:4] == 4'd3);
        mem[i] = b;
      end
      mem[len] = {4'd3, 4'($urandom)};
      // instruction-level model: which unit each instruction starts and with which fields
      for (int i = 0; i < len; i++) begin
        b = mem[i];
        e.u = b[7] ? 2'd1 : (b[7:4] == 4'd1) ? 2'd2 : (b[7:4] == 4'd2) ? 2'd3 : 2'd0;
        e.op = b[6:4]; e.ri = {4'd0, b[3:2]}; e.rj = {4'd0, b[1:0]};
        if (e.u != 2'd0) exp_q.push_back(e);
      end
      lat_lo = 1; lat_hi = 6; spur = 1; auto_done = 1; run = 1;
      wait_halt(2000);
      n_chk++; if ({imem_addr, retired} !== {6'(len), 16'(len)}) begin n_fail++; $display("FAIL rnd_end r%0d: pc=%0d retired=%0d want %0d", r, imem_addr, retired, len); end
      n_chk++; if (starts.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_nstarts r%0d: got %0d want %0d", r, starts.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++;
        if (starts[i].u !== exp_q[i].u || starts[i].ri !== exp_q[i].ri || starts[i].rj !== exp_q[i].rj
            || (exp_q[i].u == 2'd1 && starts[i].op !== exp_q[i].op)) begin
          n_fail++; $display("FAIL rnd_start r%0d i%0d: got %h want %h", r, i, starts[i], exp_q[i]);
        end
      end
    end
    n_chk++; if (stab_err != 0 || n_multi != 0) begin n_fail++; $display("FAIL rnd_pulses: stable_err=%0d multi=%0d want 0 0", stab_err, n_multi); end
  endtask

  initial begin
    fill_mem(8'h00);
    test_reset();
    test_program();
    test_nop();
    test_ignore_other_done();
    test_run_drop();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
